// File: rtl/regfile_mp_pkg.sv
// Shared types and default sizing for the multi-read-port register file.
package regfile_mp_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_DEPTH  = 16;

endpackage

// File: rtl/regfile_rd_port.sv
// One registered read port: range check, write-to-read bypass and output register.
module regfile_rd_port #(
    parameter int DATA_W   = 16,
    parameter int DEPTH    = 16,
    parameter int ADDR_W   = 4,
    parameter bit ZERO_REG = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_rd_acc,
    input  logic [ADDR_W-1:0] i_rd_addr,
    input  logic              i_wr_do,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic [DATA_W-1:0] i_mem_q,
    output logic [DATA_W-1:0] o_rd_data,
    output logic              o_rd_valid,
    output logic              o_oor
);

    localparam logic [ADDR_W:0] LP_DEPTH = (ADDR_W+1)'(DEPTH);

    logic              w_in_range;
    logic              w_zero;
    logic              w_bypass;
    logic [DATA_W-1:0] w_rd_nxt;

    assign w_in_range = {1'b0, i_rd_addr} < LP_DEPTH;
    assign w_zero     = ZERO_REG && (i_rd_addr == '0);
    // i_wr_do already excludes dropped writes, so a bypass never exposes them
    assign w_bypass   = i_wr_do && (i_wr_addr == i_rd_addr);
    assign o_oor      = i_rd_acc & ~w_in_range;

    always_comb begin
        w_rd_nxt = i_mem_q;
        if (!w_in_range || w_zero) begin
            w_rd_nxt = '0;
        end else if (w_bypass) begin
            w_rd_nxt = i_wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_rd_data  <= '0;
            o_rd_valid <= 1'b0;
        end else begin
            o_rd_valid <= i_rd_acc;
            if (i_rd_acc) begin
                o_rd_data <= w_rd_nxt;
            end
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port register file with write bypass, optional zero entry and a clear sweep.
// state    | meaning
// ST_CLEAR | sweep zeroes entry clr_ptr each cycle, accesses ignored, busy=1
// ST_IDLE  | normal read/write operation
module regfile_mp
    import regfile_mp_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int ADDR_W   = $clog2(DEPTH),
    parameter int N_RD     = 2,
    parameter bit ZERO_REG = 1'b0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     init_req,
    output logic                     busy,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic [N_RD-1:0]          rd_en,
    input  logic [N_RD*ADDR_W-1:0]   rd_addr,
    output logic [N_RD*DATA_W-1:0]   rd_data,
    output logic [N_RD-1:0]          rd_valid,
    output logic                     addr_err
);

    localparam logic [ADDR_W:0]   LP_DEPTH = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LP_LAST  = ADDR_W'(DEPTH-1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_clr_ptr;
    logic [DATA_W-1:0] r_mem [DEPTH];

    logic              w_idle;
    logic              w_start;
    logic              w_clr_last;
    logic              w_wr_in_range;
    logic              w_wr_do;
    logic              w_wr_oor;
    logic [N_RD-1:0]   w_rd_oor;

    assign w_idle        = (r_state == ST_IDLE);
    assign w_start       = w_idle & init_req;
    assign w_clr_last    = (r_state == ST_CLEAR) && (r_clr_ptr == LP_LAST);
    assign w_wr_in_range = {1'b0, wr_addr} < LP_DEPTH;
    assign w_wr_do       = w_idle & wr_en & w_wr_in_range & ~(ZERO_REG && (wr_addr == '0));
    assign w_wr_oor      = w_idle & wr_en & ~w_wr_in_range;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_CLEAR;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (init_req)   w_state_nxt = ST_CLEAR;
            ST_CLEAR: if (w_clr_last) w_state_nxt = ST_IDLE;
            default:                  w_state_nxt = ST_CLEAR;
        endcase
    end

    always_comb begin
        busy = (r_state == ST_CLEAR);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_clr_ptr <= '0;
        end else if (w_start || w_clr_last) begin
            r_clr_ptr <= '0;
        end else if (r_state == ST_CLEAR) begin
            r_clr_ptr <= r_clr_ptr + ADDR_W'(1);
        end
    end

    // Array is deliberately not reset; the sweep owns initialisation
    always_ff @(posedge clk) begin
        if (r_state == ST_CLEAR) begin
            r_mem[r_clr_ptr] <= '0;
        end else if (w_wr_do) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    // An accepted bad access in the init_req cycle still leaves the error visible
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_err <= 1'b0;
        end else if (w_wr_oor || (|w_rd_oor)) begin
            addr_err <= 1'b1;
        end else if (w_start) begin
            addr_err <= 1'b0;
        end
    end

    for (genvar p = 0; p < N_RD; p++) begin : g_rd
        logic [ADDR_W-1:0] w_addr;
        logic [DATA_W-1:0] w_mem_q;

        assign w_addr  = rd_addr[p*ADDR_W +: ADDR_W];
        assign w_mem_q = r_mem[w_addr];

        regfile_rd_port #(
            .DATA_W   (DATA_W),
            .DEPTH    (DEPTH),
            .ADDR_W   (ADDR_W),
            .ZERO_REG (ZERO_REG)
        ) u_rd_port (
            .clk        (clk),
            .rst_n      (rst_n),
            .i_rd_acc   (w_idle & rd_en[p]),
            .i_rd_addr  (w_addr),
            .i_wr_do    (w_wr_do),
            .i_wr_addr  (wr_addr),
            .i_wr_data  (wr_data),
            .i_mem_q    (w_mem_q),
            .o_rd_data  (rd_data[p*DATA_W +: DATA_W]),
            .o_rd_valid (rd_valid[p]),
            .o_oor      (w_rd_oor[p])
        );
    end

endmodule
